// File: rtl/alu_pkg.sv
// Shared encodings for the ALU slice: function codes, unit-select values
// and the compare result codes.
package alu_pkg;

    // Arithmetic unit
    localparam logic [3:0] ADD    = 4'b0000;
    localparam logic [3:0] SUB    = 4'b0001;
    localparam logic [3:0] MUL    = 4'b0010;
    localparam logic [3:0] DIV    = 4'b0011;

    // Logic unit
    localparam logic [3:0] AND    = 4'b0100;
    localparam logic [3:0] OR     = 4'b0101;
    localparam logic [3:0] NAND   = 4'b0110;
    localparam logic [3:0] NOR    = 4'b0111;

    // Compare unit
    localparam logic [3:0] NOP    = 4'b1000;
    localparam logic [3:0] CMP_EQ = 4'b1001;
    localparam logic [3:0] CMP_GT = 4'b1010;
    localparam logic [3:0] CMP_LT = 4'b1011;

    // Shift unit
    localparam logic [3:0] SHR_A  = 4'b1100;
    localparam logic [3:0] SHL_A  = 4'b1101;
    localparam logic [3:0] SHR_B  = 4'b1110;
    localparam logic [3:0] SHL_B  = 4'b1111;

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } unit_e;

    localparam logic [1:0] CMP_RES_NONE = 2'd0;
    localparam logic [1:0] CMP_RES_EQ   = 2'd1;
    localparam logic [1:0] CMP_RES_GT   = 2'd2;
    localparam logic [1:0] CMP_RES_LT   = 2'd3;

endpackage

// File: rtl/alu_decoder.sv
// Maps the unit-select field of the function code onto one-hot unit enables.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] unit_sel,
    output logic       arith_en,
    output logic       logic_en,
    output logic       cmp_en,
    output logic       shift_en
);

    always_comb begin
        arith_en = 1'b0;
        logic_en = 1'b0;
        cmp_en   = 1'b0;
        shift_en = 1'b0;
        case (unit_e'(unit_sel))
            UNIT_ARITH: arith_en = 1'b1;
            UNIT_LOGIC: logic_en = 1'b1;
            UNIT_CMP:   cmp_en   = 1'b1;
            UNIT_SHIFT: shift_en = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/alu_top.sv
// Single-cycle signed ALU: four functional units, each with its own registered
// result and flag; only the selected unit produces a non-zero result.
module alu_top
    import alu_pkg::*;
#(
    parameter int OP_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [OP_WIDTH-1:0]     A,
    input  logic [OP_WIDTH-1:0]     B,
    input  logic [3:0]              ALU_FUN,
    output logic [2*OP_WIDTH-1:0]   Arith_OUT,
    output logic                    Arith_Flag,
    output logic [OP_WIDTH-1:0]     Logic_OUT,
    output logic                    Logic_Flag,
    output logic [OP_WIDTH-1:0]     CMP_OUT,
    output logic                    CMP_Flag,
    output logic [OP_WIDTH-1:0]     SHIFT_OUT,
    output logic                    SHIFT_Flag
);

    localparam int RW = 2 * OP_WIDTH;

    logic arith_en;
    logic logic_en;
    logic cmp_en;
    logic shift_en;

    alu_decoder u_alu_decoder (
        .unit_sel (ALU_FUN[3:2]),
        .arith_en (arith_en),
        .logic_en (logic_en),
        .cmp_en   (cmp_en),
        .shift_en (shift_en)
    );

    // Operands widened to the result width so most-negative / -1 cannot wrap.
    logic signed [RW-1:0]       a_ext;
    logic signed [RW-1:0]       b_ext;
    logic signed [OP_WIDTH-1:0] a_s;
    logic signed [OP_WIDTH-1:0] b_s;

    assign a_ext = {{OP_WIDTH{A[OP_WIDTH-1]}}, A};
    assign b_ext = {{OP_WIDTH{B[OP_WIDTH-1]}}, B};
    assign a_s   = A;
    assign b_s   = B;

    logic [RW-1:0]       arith_nxt;
    logic [OP_WIDTH-1:0] logic_nxt;
    logic [OP_WIDTH-1:0] cmp_nxt;
    logic [OP_WIDTH-1:0] shift_nxt;

    always_comb begin
        arith_nxt = '0;
        if (arith_en) begin
            case (ALU_FUN)
                ADD:     arith_nxt = a_ext + b_ext;
                SUB:     arith_nxt = a_ext - b_ext;
                MUL:     arith_nxt = a_ext * b_ext;
                DIV:     if (B != '0) arith_nxt = a_ext / b_ext;
                default: arith_nxt = '0;
            endcase
        end
    end

    always_comb begin
        logic_nxt = '0;
        if (logic_en) begin
            case (ALU_FUN)
                AND:     logic_nxt = A & B;
                OR:      logic_nxt = A | B;
                NAND:    logic_nxt = ~(A & B);
                NOR:     logic_nxt = ~(A | B);
                default: logic_nxt = '0;
            endcase
        end
    end

    always_comb begin
        cmp_nxt = '0;
        if (cmp_en) begin
            case (ALU_FUN)
                NOP:     cmp_nxt = OP_WIDTH'(CMP_RES_NONE);
                CMP_EQ:  if (a_s == b_s) cmp_nxt = OP_WIDTH'(CMP_RES_EQ);
                CMP_GT:  if (a_s > b_s)  cmp_nxt = OP_WIDTH'(CMP_RES_GT);
                CMP_LT:  if (a_s < b_s)  cmp_nxt = OP_WIDTH'(CMP_RES_LT);
                default: cmp_nxt = '0;
            endcase
        end
    end

    always_comb begin
        shift_nxt = '0;
        if (shift_en) begin
            case (ALU_FUN)
                SHR_A:   shift_nxt = A >> 1;
                SHL_A:   shift_nxt = A << 1;
                SHR_B:   shift_nxt = B >> 1;
                SHL_B:   shift_nxt = B << 1;
                default: shift_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Arith_OUT  <= '0;
            Logic_OUT  <= '0;
            CMP_OUT    <= '0;
            SHIFT_OUT  <= '0;
            Arith_Flag <= 1'b0;
            Logic_Flag <= 1'b0;
            CMP_Flag   <= 1'b0;
            SHIFT_Flag <= 1'b0;
        end else begin
            Arith_OUT  <= arith_nxt;
            Logic_OUT  <= logic_nxt;
            CMP_OUT    <= cmp_nxt;
            SHIFT_OUT  <= shift_nxt;
            Arith_Flag <= arith_en;
            Logic_Flag <= logic_en;
            CMP_Flag   <= cmp_en;
            SHIFT_Flag <= shift_en;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Directed and randomised checks of alu_top through an expected-result queue.
module tb_alu_top;

    localparam int N = 16;

    typedef struct {
        logic [2*N-1:0] arith;
        logic [N-1:0]   lo;
        logic [N-1:0]   cm;
        logic [N-1:0]   sh;
        logic [3:0]     flags;
        logic [8*12-1:0] tag;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [3:0]     ALU_FUN;
    logic [2*N-1:0] Arith_OUT;
    logic           Arith_Flag;
    logic [N-1:0]   Logic_OUT;
    logic           Logic_Flag;
    logic [N-1:0]   CMP_OUT;
    logic           CMP_Flag;
    logic [N-1:0]   SHIFT_OUT;
    logic           SHIFT_Flag;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    alu_top #(.OP_WIDTH(N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .Arith_OUT  (Arith_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_OUT  (SHIFT_OUT),
        .SHIFT_Flag (SHIFT_Flag)
    );

    function automatic exp_t mk(int arith, logic [N-1:0] lo, logic [N-1:0] cm,
                                logic [N-1:0] sh, logic [3:0] flags);
        exp_t e;
        e.arith = arith;
        e.lo    = lo;
        e.cm    = cm;
        e.sh    = sh;
        e.flags = flags;
        e.tag   = '0;
        return e;
    endfunction

    // Reference behaviour written with plain integer arithmetic.
    function automatic exp_t model(logic [3:0] fun, logic [N-1:0] a, logic [N-1:0] b);
        int ai;
        int bi;
        int r;
        logic [N-1:0] lo;
        logic [N-1:0] cm;
        logic [N-1:0] sh;
        logic [3:0] fl;
        ai = int'($signed(a));
        bi = int'($signed(b));
        r  = 0;
        lo = '0;
        cm = '0;
        sh = '0;
        fl = 4'b0000;
        case (fun[3:2])
            2'b00: begin
                fl = 4'b1000;
                case (fun[1:0])
                    2'b00: r = ai + bi;
                    2'b01: r = ai - bi;
                    2'b10: r = ai * bi;
                    default: r = (bi == 0) ? 0 : ai / bi;
                endcase
            end
            2'b01: begin
                fl = 4'b0100;
                case (fun[1:0])
                    2'b00: lo = a & b;
                    2'b01: lo = a | b;
                    2'b10: lo = ~(a & b);
                    default: lo = ~(a | b);
                endcase
            end
            2'b10: begin
                fl = 4'b0010;
                case (fun[1:0])
                    2'b00: cm = 0;
                    2'b01: cm = (ai == bi) ? 1 : 0;
                    2'b10: cm = (ai > bi) ? 2 : 0;
                    default: cm = (ai < bi) ? 3 : 0;
                endcase
            end
            default: begin
                fl = 4'b0001;
                case (fun[1:0])
                    2'b00: sh = {1'b0, a[N-1:1]};
                    2'b01: sh = {a[N-2:0], 1'b0};
                    2'b10: sh = {1'b0, b[N-1:1]};
                    default: sh = {b[N-2:0], 1'b0};
                endcase
            end
        endcase
        return mk(r, lo, cm, sh, fl);
    endfunction

    task automatic check_pop();
        exp_t e;
        logic [3:0] fl;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL queue_empty: observed 0 entries expected 1");
        end
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            fl = {Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag};
            n_cmp++;
            assert (Arith_OUT === e.arith) else begin
                n_fail++;
                $error("FAIL %s arith: observed %h expected %h", e.tag, Arith_OUT, e.arith);
            end
            n_cmp++;
            assert (Logic_OUT === e.lo) else begin
                n_fail++;
                $error("FAIL %s logic: observed %h expected %h", e.tag, Logic_OUT, e.lo);
            end
            n_cmp++;
            assert (CMP_OUT === e.cm) else begin
                n_fail++;
                $error("FAIL %s cmp: observed %h expected %h", e.tag, CMP_OUT, e.cm);
            end
            n_cmp++;
            assert (SHIFT_OUT === e.sh) else begin
                n_fail++;
                $error("FAIL %s shift: observed %h expected %h", e.tag, SHIFT_OUT, e.sh);
            end
            n_cmp++;
            assert (fl === e.flags) else begin
                n_fail++;
                $error("FAIL %s flags: observed %b expected %b", e.tag, fl, e.flags);
            end
        end
    endtask

    task automatic step(logic rst, logic [3:0] fun, logic [N-1:0] a, logic [N-1:0] b,
                        exp_t e, logic [8*12-1:0] tag);
        @(negedge CLK);
        RST     = rst;
        ALU_FUN = fun;
        A       = a;
        B       = b;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check_pop();
    endtask

    initial begin
        logic [3:0]   rf;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        RST     = 1'b1;
        ALU_FUN = 4'b0010;
        A       = 16'h1234;
        B       = 16'h5678;

        step(1'b1, 4'b0010, 16'h1234, 16'h5678, mk(0, 0, 0, 0, 4'b0000), "reset");
        step(1'b0, 4'b0000, -16'sd10, -16'sd4, mk(-14, 0, 0, 0, 4'b1000), "add_nn");

        step(1'b0, 4'b0001, 16'sd10, -16'sd4, mk(14, 0, 0, 0, 4'b1000), "sub_pn");
        step(1'b0, 4'b0010, -16'sd10, 16'sd4, mk(-40, 0, 0, 0, 4'b1000), "mul_np");
        step(1'b0, 4'b0011, -16'sd10, -16'sd5, mk(2, 0, 0, 0, 4'b1000), "div_nn");
        step(1'b0, 4'b0011, 16'sd10, -16'sd5, mk(-2, 0, 0, 0, 4'b1000), "div_pn");
        step(1'b0, 4'b0011, 16'sd7, 16'sd0, mk(0, 0, 0, 0, 4'b1000), "div_zero");
        step(1'b0, 4'b0011, 16'h8000, 16'hFFFF, mk(32768, 0, 0, 0, 4'b1000), "div_ovf");
        step(1'b0, 4'b0010, 16'h8000, 16'h8000, mk(32'h4000_0000, 0, 0, 0, 4'b1000), "mul_max");
        step(1'b0, 4'b0000, 16'h7FFF, 16'h7FFF, mk(65534, 0, 0, 0, 4'b1000), "add_max");
        step(1'b0, 4'b0001, 16'h8000, 16'h7FFF, mk(-65535, 0, 0, 0, 4'b1000), "sub_min");

        step(1'b0, 4'b0100, 16'h0002, 16'h0001, mk(0, 16'h0000, 0, 0, 4'b0100), "and");
        step(1'b0, 4'b0101, 16'h0002, 16'h0001, mk(0, 16'h0003, 0, 0, 4'b0100), "or");
        step(1'b0, 4'b0110, 16'h0002, 16'h0001, mk(0, 16'hFFFF, 0, 0, 4'b0100), "nand");
        step(1'b0, 4'b0111, 16'h0002, 16'h0001, mk(0, 16'hFFFC, 0, 0, 4'b0100), "nor");

        step(1'b0, 4'b1001, 16'sd1, 16'sd1, mk(0, 0, 1, 0, 4'b0010), "cmp_eq");
        step(1'b0, 4'b1010, 16'sd2, 16'sd1, mk(0, 0, 2, 0, 4'b0010), "cmp_gt");
        step(1'b0, 4'b1011, 16'sd1, 16'sd2, mk(0, 0, 3, 0, 4'b0010), "cmp_lt");
        step(1'b0, 4'b1010, -16'sd1, 16'sd1, mk(0, 0, 0, 0, 4'b0010), "cmp_gt_sgn");
        step(1'b0, 4'b1011, -16'sd1, 16'sd1, mk(0, 0, 3, 0, 4'b0010), "cmp_lt_sgn");
        step(1'b0, 4'b1000, 16'sd5, 16'sd5, mk(0, 0, 0, 0, 4'b0010), "cmp_nop");

        step(1'b0, 4'b1100, 16'h0002, 16'h0000, mk(0, 0, 0, 16'h0001, 4'b0001), "shr_a");
        step(1'b0, 4'b1101, 16'h8001, 16'h0000, mk(0, 0, 0, 16'h0002, 4'b0001), "shl_a");
        step(1'b0, 4'b1110, 16'h0000, 16'h0002, mk(0, 0, 0, 16'h0001, 4'b0001), "shr_b");
        step(1'b0, 4'b1111, 16'h0000, 16'h0001, mk(0, 0, 0, 16'h0002, 4'b0001), "shl_b");

        step(1'b0, 4'b0000, 16'sd3, 16'sd4, mk(7, 0, 0, 0, 4'b1000), "b2b_add");
        step(1'b0, 4'b0100, 16'h00F0, 16'h0FF0, mk(0, 16'h00F0, 0, 0, 4'b0100), "b2b_and");
        step(1'b0, 4'b1001, 16'sd5, 16'sd5, mk(0, 0, 1, 0, 4'b0010), "b2b_cmp_eq");
        step(1'b0, 4'b1101, 16'h4000, 16'h0000, mk(0, 0, 0, 16'h8000, 4'b0001), "b2b_shl_a");

        step(1'b0, 4'b0010, 16'sd100, 16'sd3, mk(300, 0, 0, 0, 4'b1000), "pre_rst");
        step(1'b1, 4'b0000, 16'sd9, 16'sd9, mk(0, 0, 0, 0, 4'b0000), "rst_prio");

        for (int i = 0; i < 60; i++) begin
            rf = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 7 == 0) rb = '0;
            if (i % 11 == 0) rb = ra;
            step(1'b0, rf, ra, rb, model(rf, ra, rb), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
